pragmatic_term_scheduler: RTL and testbench
===========================================

PRAGMATIC_TERM_SCHEDULER -- requirements
Module: pragmatic_term_scheduler

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8: activation and weight width in bits.
REQ-002 SHALL have parameter VEC_LENGTH, default 8: number of lanes, one activation/weight pair per lane.
REQ-003 SHALL have port clk  input  1  the single clock; all state updates on its rising edge.
REQ-004 SHALL have port reset  input  1  reset, asynchronous and active-high.
REQ-005 SHALL have port in_valid  input  1  a new activation/weight vector is presented.
REQ-006 SHALL have port in_ready  output  1  the block accepts a vector this cycle.
REQ-007 SHALL have port act  input  signed DATA_WIDTH x VEC_LENGTH (unpacked)  activations.
REQ-008 SHALL have port weight  input  signed DATA_WIDTH x VEC_LENGTH (unpacked)  weights to decompose into power-of-two terms.
REQ-009 SHALL have port out_valid  output  1  the term-group outputs are valid.
REQ-010 SHALL have port out_ready  input  1  the downstream MAC consumes the current term group.
REQ-011 SHALL have port out_last  output  1  the current group is the final group of the vector.
REQ-012 SHALL have port act_in  output  signed DATA_WIDTH x VEC_LENGTH  latched activations, held for the whole vector.
REQ-013 SHALL have port shift_1st_sel  output  2 x VEC_LENGTH  per-lane offset of the term above the group base.
REQ-014 SHALL have port shift_1st_en  output  1 x VEC_LENGTH  the lane contributes a term in this group.
REQ-015 SHALL have port is_neg  output  1 x VEC_LENGTH  the lane term is negative (weight < 0).
REQ-016 SHALL have port shift_2nd_sel  output  3  group base bit position, 0..7.
REQ-017 SHALL have port shift_2nd_en  output  1  the group contains at least one enabled lane.

Function
REQ-018 SHALL implement a two-state FSM, IDLE and RUN; in_ready = 1 exactly when state is IDLE and reset is low.
REQ-019 SHALL, on in_valid && in_ready, latch act into act_in, store sign[j] = weight[j][MSB], and store mag[j] = |weight[j]| as an unsigned DATA_WIDTH value (-128 -> 8'h80), then enter RUN on the next cycle.
REQ-020 SHALL hold out_valid = 1 in RUN and 0 in IDLE; there is a one-cycle bubble between vectors (no accept while in RUN).
REQ-021 SHALL compute base = the lowest set-bit position over all nonzero mag[j]; shift_2nd_sel = base and shift_2nd_en = 1 when any mag is nonzero.
REQ-022 SHALL, for each lane whose mag has a set bit in [base, base+3], drive shift_1st_en = 1 and shift_1st_sel = (lowest such bit - base); otherwise shift_1st_en = 0 and shift_1st_sel = 0.
REQ-023 SHALL drive is_neg[j] = sign[j] when shift_1st_en[j] = 1, else 0.
REQ-024 SHALL, on out_valid && out_ready, clear exactly the emitted bit in each enabled lane's mag; all outputs stay stable while out_ready = 0.
REQ-025 SHALL assert out_last when no lane holds a set bit other than the bit emitted in the current group; a handshake with out_last = 1 returns the FSM to IDLE.
REQ-026 SHALL, if every latched weight is zero, emit exactly one group with all shift_1st_en = 0, shift_2nd_en = 0, shift_2nd_sel = 0, out_last = 1.
REQ-027 SHALL issue groups in strictly increasing base order; each weight bit is emitted exactly once, so sum over groups of (+/-)2^(base+sel) equals weight[j] for every lane.
REQ-028 SHALL compute all group outputs combinationally from registered state, with no extra latency; the vector issue cycle count equals the number of groups.

Reset
REQ-029 SHALL, while reset is high, immediately force state IDLE, all mag/sign/act_in to 0, and all outputs to 0 (including in_ready); a vector in progress is discarded.
REQ-030 SHALL accept a new vector on the first rising edge after reset deasserts if in_valid = 1.

Verification
REQ-031 SHALL verify: all weights = 1 -> one group with base 0, all shift_1st_en = 1, sel 0, is_neg 0, out_last 1.
REQ-032 SHALL verify: w0 = 5, w1 = 8, others 0 -> group1 base 0 (lane0 sel 0, lane1 sel 3); group2 base 2 (lane0 sel 0), out_last.
REQ-033 SHALL verify: w0 = -127, others 0 -> 7 groups with bases 0..6, lane0 sel 0, is_neg 1; last group flagged.
REQ-034 SHALL verify: w0 = -128 -> one group with base 7, sel 0, is_neg 1, out_last 1; all-zero weights -> one group with shift_2nd_en 0, out_last 1.
REQ-035 SHALL verify: out_ready held low for 3 cycles mid-vector -> outputs constant and no bits cleared; the group sequence resumes unchanged.
REQ-036 SHALL verify: reset asserted during group 2 of w0 = -127 -> outputs 0 asynchronously; after release in_ready = 1 and a fresh vector schedules from base 0.

Source files
------------

// File: rtl/pragmatic_term_scheduler_if.sv
// pragmatic_term_scheduler_if: vector input and term-group output bundle for the term scheduler
interface pragmatic_term_scheduler_if #(
  parameter int DATA_WIDTH = 8,
  parameter int VEC_LENGTH = 8
);
  localparam int BW = $clog2(DATA_WIDTH);
  logic in_valid;
  logic in_ready;
  logic signed [DATA_WIDTH-1:0] act [VEC_LENGTH];
  logic signed [DATA_WIDTH-1:0] weight [VEC_LENGTH];
  logic out_valid;
  logic out_ready;
  logic out_last;
  logic signed [DATA_WIDTH-1:0] act_in [VEC_LENGTH];
  logic [1:0] shift_1st_sel [VEC_LENGTH];
  logic [VEC_LENGTH-1:0] shift_1st_en;
  logic [VEC_LENGTH-1:0] is_neg;
  logic [BW-1:0] shift_2nd_sel;
  logic shift_2nd_en;
  modport master (
    output in_valid, act, weight, out_ready,
    input in_ready, out_valid, out_last, act_in, shift_1st_sel, shift_1st_en, is_neg,
    shift_2nd_sel, shift_2nd_en
  );
  modport slave (
    input in_valid, act, weight, out_ready,
    output in_ready, out_valid, out_last, act_in, shift_1st_sel, shift_1st_en, is_neg,
    shift_2nd_sel, shift_2nd_en
  );
endinterface

// File: rtl/pragmatic_term_scheduler.sv
// pragmatic_term_scheduler: splits a weight vector into power-of-two term groups sharing a 4-bit window
module pragmatic_term_scheduler #(
  parameter int DATA_WIDTH = 8,
  parameter int VEC_LENGTH = 8
) (
  input logic clk,
  input logic reset,
  pragmatic_term_scheduler_if.slave bus
);
  localparam int BW = $clog2(DATA_WIDTH);
  typedef enum logic {IDLE, RUN} state_t;
  state_t state;
  logic signed [DATA_WIDTH-1:0] act_q [VEC_LENGTH];
  logic [DATA_WIDTH-1:0] mag [VEC_LENGTH];
  logic [VEC_LENGTH-1:0] sign;
  logic [DATA_WIDTH-1:0] or_all;
  logic [BW-1:0] base;
  logic [3:0] win [VEC_LENGTH];
  logic [3:0] iso [VEC_LENGTH];
  logic [DATA_WIDTH-1:0] rem [VEC_LENGTH];
  logic last;
  logic run;
  always_comb begin
    run = state == RUN;
    or_all = '0;
    for (int j = 0; j < VEC_LENGTH; j++) or_all = or_all | mag[j];
    base = '0;
    for (int i = DATA_WIDTH - 1; i >= 0; i--) if (or_all[i]) base = BW'(i);
    last = 1'b1;
    // iso isolates the lowest set bit of each lane's window; rem is the mag left after this group
    for (int j = 0; j < VEC_LENGTH; j++) begin
      win[j] = 4'(mag[j] >> base);
      iso[j] = win[j] & (~win[j] + 4'd1);
      rem[j] = mag[j] & ~(DATA_WIDTH'(iso[j]) << base);
      if (rem[j] != '0) last = 1'b0;
      bus.act_in[j] = act_q[j];
      bus.shift_1st_en[j] = run && (win[j] != 4'd0);
      bus.is_neg[j] = run && (win[j] != 4'd0) && sign[j];
      bus.shift_1st_sel[j] = run ? {iso[j][3] | iso[j][2], iso[j][3] | iso[j][1]} : 2'd0;
    end
    bus.shift_2nd_sel = run ? base : '0;
    bus.shift_2nd_en = run && (or_all != '0);
    bus.out_last = run && last;
    bus.out_valid = run;
    bus.in_ready = (state == IDLE) && !reset;
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      sign <= '0;
      for (int j = 0; j < VEC_LENGTH; j++) begin
        act_q[j] <= '0;
        mag[j] <= '0;
      end
    end else if (state == IDLE) begin
      if (bus.in_valid) begin
        state <= RUN;
        for (int j = 0; j < VEC_LENGTH; j++) begin
          act_q[j] <= bus.act[j];
          sign[j] <= bus.weight[j][DATA_WIDTH-1];
          mag[j] <= bus.weight[j][DATA_WIDTH-1] ? DATA_WIDTH'(-bus.weight[j]) : DATA_WIDTH'(bus.weight[j]);
        end
      end
    end else if (bus.out_ready) begin
      for (int j = 0; j < VEC_LENGTH; j++) mag[j] <= rem[j];
      if (last) state <= IDLE;
    end
  end
endmodule

// File: tb/tb_pragmatic_term_scheduler.sv
// tb_pragmatic_term_scheduler: directed vectors with a group scoreboard checked by a handshake monitor
module tb_pragmatic_term_scheduler;
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;
  pragmatic_term_scheduler_if #(.DATA_WIDTH(8), .VEC_LENGTH(8)) ifc ();
  pragmatic_term_scheduler #(.DATA_WIDTH(8), .VEC_LENGTH(8)) dut (.clk(clk), .reset(reset), .bus(ifc));
  typedef struct packed {
    logic [2:0] base;
    logic [7:0] en;
    logic [15:0] sel;
    logic [7:0] neg;
    logic last;
    logic en2;
    logic [63:0] act;
  } grp_t;
  grp_t sb [$];
  int checks = 0;
  int failures = 0;
  logic [63:0] cur_act = '0;
  task automatic chk(input string name, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", name, got, exp);
    end
  endtask
  function automatic grp_t observed();
    grp_t g;
    g.base = ifc.shift_2nd_sel;
    g.en = ifc.shift_1st_en;
    g.neg = ifc.is_neg;
    g.last = ifc.out_last;
    g.en2 = ifc.shift_2nd_en;
    g.sel = '0;
    g.act = '0;
    for (int j = 0; j < 8; j++) begin
      g.sel[2*j +: 2] = ifc.shift_1st_sel[j];
      g.act[8*j +: 8] = ifc.act_in[j];
    end
    return g;
  endfunction
  task automatic expect_grp(input logic [2:0] b, input logic [7:0] en, input logic [15:0] sel,
                            input logic [7:0] neg, input logic last, input logic en2);
    grp_t g;
    g.base = b;
    g.en = en;
    g.sel = sel;
    g.neg = neg;
    g.last = last;
    g.en2 = en2;
    g.act = cur_act;
    sb.push_back(g);
  endtask
  task automatic set_act(input logic [7:0] seed);
    cur_act = {8{seed}} ^ 64'h0123_4567_89AB_CDEF;
  endtask
  task automatic send(input logic [63:0] w);
    int n;
    n = 0;
    while (!ifc.in_ready && n < 100) begin
      @(posedge clk);
      #1 n++;
    end
    if (!ifc.in_ready) chk("in_ready_timeout", 0, 1);
    for (int j = 0; j < 8; j++) begin
      ifc.weight[j] = w[8*j +: 8];
      ifc.act[j] = cur_act[8*j +: 8];
    end
    ifc.in_valid = 1'b1;
    @(posedge clk);
    #1 ifc.in_valid = 1'b0;
  endtask
  task automatic wait_done();
    int n;
    n = 0;
    while (sb.size() != 0 && n < 200) begin
      @(posedge clk);
      n++;
    end
    if (sb.size() != 0) chk("drain_timeout", 128'(sb.size()), 0);
    #1;
  endtask
  always @(negedge clk) begin
    grp_t e;
    if (!reset && ifc.out_valid && ifc.out_ready) begin
      if (sb.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL extra_group got base=%0d en=%0h exp none", ifc.shift_2nd_sel, ifc.shift_1st_en);
      end else begin
        e = sb.pop_front();
        chk("group", 128'(observed()), 128'(e));
      end
    end
  end
  initial begin
    ifc.in_valid = 1'b0;
    ifc.out_ready = 1'b1;
    for (int j = 0; j < 8; j++) begin
      ifc.act[j] = '0;
      ifc.weight[j] = '0;
    end
    #1;
    chk("rst_in_ready", 128'(ifc.in_ready), 0);
    chk("rst_out_valid", 128'(ifc.out_valid), 0);
    @(posedge clk);
    #2 reset = 1'b0;
    #1;
    chk("post_rst_in_ready", 128'(ifc.in_ready), 1);
    chk("post_rst_out_last", 128'(ifc.out_last), 0);
    set_act(8'h11);
    expect_grp(3'd0, 8'hFF, 16'h0000, 8'h00, 1'b1, 1'b1);
    send(64'h0101_0101_0101_0101);
    wait_done();
    set_act(8'h22);
    expect_grp(3'd0, 8'h03, 16'h000C, 8'h00, 1'b0, 1'b1);
    expect_grp(3'd2, 8'h01, 16'h0000, 8'h00, 1'b1, 1'b1);
    send(64'h0000_0000_0000_0805);
    wait_done();
    set_act(8'h33);
    for (int i = 0; i < 7; i++) expect_grp(3'(i), 8'h01, 16'h0000, 8'h01, i == 6, 1'b1);
    send(64'h0000_0000_0000_0081);
    wait_done();
    set_act(8'h44);
    expect_grp(3'd7, 8'h01, 16'h0000, 8'h01, 1'b1, 1'b1);
    send(64'h0000_0000_0000_0080);
    wait_done();
    set_act(8'h55);
    expect_grp(3'd0, 8'h00, 16'h0000, 8'h00, 1'b1, 1'b0);
    send(64'h0000_0000_0000_0000);
    wait_done();
    set_act(8'h66);
    expect_grp(3'd0, 8'h05, 16'h0010, 8'h01, 1'b0, 1'b1);
    expect_grp(3'd1, 8'h0D, 16'h00D0, 8'h09, 1'b1, 1'b1);
    send(64'h0000_0000_F006_00FD);
    wait_done();
    set_act(8'h77);
    for (int i = 0; i < 7; i++) expect_grp(3'(i), 8'h01, 16'h0000, 8'h01, i == 6, 1'b1);
    send(64'h0000_0000_0000_0081);
    @(posedge clk);
    #1 ifc.out_ready = 1'b0;
    repeat (3) begin
      @(negedge clk);
      chk("stall_valid", 128'(ifc.out_valid), 1);
      chk("stall_base", 128'(ifc.shift_2nd_sel), 1);
      chk("stall_en", 128'(ifc.shift_1st_en), 1);
      chk("stall_last", 128'(ifc.out_last), 0);
    end
    @(posedge clk);
    #1 ifc.out_ready = 1'b1;
    wait_done();
    set_act(8'h88);
    for (int i = 0; i < 7; i++) expect_grp(3'(i), 8'h01, 16'h0000, 8'h01, i == 6, 1'b1);
    send(64'h0000_0000_0000_0081);
    @(posedge clk);
    #2 reset = 1'b1;
    #1;
    chk("arst_out_valid", 128'(ifc.out_valid), 0);
    chk("arst_in_ready", 128'(ifc.in_ready), 0);
    chk("arst_en", 128'(ifc.shift_1st_en), 0);
    chk("arst_base", 128'(ifc.shift_2nd_sel), 0);
    chk("arst_neg", 128'(ifc.is_neg), 0);
    chk("arst_act_in", 128'(ifc.act_in[0]), 0);
    sb.delete();
    @(posedge clk);
    #2 reset = 1'b0;
    #1;
    chk("rel_in_ready", 128'(ifc.in_ready), 1);
    set_act(8'h99);
    expect_grp(3'd0, 8'h03, 16'h000C, 8'h00, 1'b0, 1'b1);
    expect_grp(3'd2, 8'h01, 16'h0000, 8'h00, 1'b1, 1'b1);
    send(64'h0000_0000_0000_0805);
    wait_done();
    @(negedge clk);
    chk("final_idle", 128'(ifc.in_ready), 1);
    chk("final_sb_empty", 128'(sb.size()), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
